// File: rtl/phase_dump_pkg.sv
// Shared types and constants for the phase snapshot capture controller.
// Holds the FSM state encoding, register bit positions and default widths.
package phase_dump_pkg;

    localparam int ARM_BIT    = 0;
    localparam int CH_SEL_LSB = 8;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CH_W   = 8;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } dump_state_t;

endpackage

// File: rtl/phase_dump_ctrl_if.sv
// Channelised phase stream in, snapshot BRAM write port out; no backpressure on either side.
// The master drives the stream and observes the BRAM port; the slave is the capture controller.
interface phase_dump_ctrl_if
    import phase_dump_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_W   = DEF_CH_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_phase;

    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;

    modport master (
        output in_valid, in_ch, in_phase,
        input  bram_we, bram_addr, bram_din
    );

    modport slave (
        input  in_valid, in_ch, in_phase,
        output bram_we, bram_addr, bram_din
    );

endinterface

// File: rtl/rise_edge_det.sv
// Rising-edge detector: rise is combinational from d against a registered history flop.
// Zero latency on rise, history updates every cycle; no backpressure.
module rise_edge_det #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= RST_VAL;
        end else begin
            hist_q <= d;
        end
    end

    assign rise = d & ~hist_q;

endmodule

// File: rtl/phase_dump_ctrl.sv
// Arms on a software 0->1 of dmp_on[0], captures 2^ADDR_W samples of one channel into BRAM.
// Matching sample at t is written at t+1; one sample per clock, no backpressure or stall.
module phase_dump_ctrl
    import phase_dump_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_W   = DEF_CH_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       dmp_on,
    phase_dump_ctrl_if.slave  bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    dump_state_t       state_q, state_d;
    logic              arm, arm_rise, arm_start, match, wr_en;
    logic [CH_W-1:0]   sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdat_q;
    logic              unused_dmp_bits;

    assign arm             = dmp_on[ARM_BIT];
    assign unused_dmp_bits = ^{dmp_on[31:CH_SEL_LSB+CH_W], dmp_on[CH_SEL_LSB-1:ARM_BIT+1]};
    assign match           = bus.in_valid && (bus.in_ch == sel_q);

    // History resets high so a register already holding 1 at reset release cannot arm.
    rise_edge_det #(.RST_VAL(1'b1)) u_arm_det (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .d     (arm),
        .rise  (arm_rise)
    );

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort (arm low) wins over a matching sample in the same cycle.
    always_comb begin
        state_d   = state_q;
        arm_start = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_rise) begin
                    state_d   = ST_ARMED;
                    arm_start = 1'b1;
                end
            end
            ST_ARMED: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (match) begin
                    wr_en   = 1'b1;
                    state_d = (addr_q == ADDR_LAST) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (match) begin
                    wr_en = 1'b1;
                    if (addr_q == ADDR_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            sel_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdat_q  <= '0;
        end else begin
            we_q <= wr_en;
            if (arm_start) begin
                sel_q  <= dmp_on[CH_SEL_LSB +: CH_W];
                addr_q <= '0;
                cnt_q  <= '0;
            end else if (wr_en) begin
                addr_q  <= addr_q + 1'b1;
                cnt_q   <= cnt_q + 1'b1;
                waddr_q <= addr_q;
                wdat_q  <= bus.in_phase;
            end
        end
    end

    assign bus.bram_we   = we_q;
    assign bus.bram_addr = waddr_q;
    assign bus.bram_din  = wdat_q;
    assign busy          = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done          = (state_q == ST_DONE);
    assign wr_count      = cnt_q;

endmodule

// File: tb/tb_phase_dump_ctrl.sv
// Vector table for arm/abort/re-arm behaviour, then directed full-depth, abort and gapped-stream runs.
`timescale 1ns/1ps
module tb_phase_dump_ctrl;
    import phase_dump_pkg::*;

    localparam int DATA_W = 16;
    localparam int CH_W   = 8;
    localparam int ADDR_W = 10;
    localparam int CW     = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NV     = 16;

    logic              user_clk = 1'b0;
    logic              user_rst_n;
    logic [31:0]       dmp_on;
    logic              busy, done;
    logic [ADDR_W:0]   wr_count;

    phase_dump_ctrl_if #(.DATA_W(DATA_W), .CH_W(CH_W), .ADDR_W(ADDR_W)) bus ();

    phase_dump_ctrl #(.DATA_W(DATA_W), .CH_W(CH_W), .ADDR_W(ADDR_W)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .dmp_on     (dmp_on),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count)
    );

    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              dn;
        logic [ADDR_W:0]   cnt;
    } wr_rec_t;

    typedef struct {
        logic [31:0]       dmp;
        logic              vld;
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] ph;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              bsy;
        logic              dn;
        logic [ADDR_W:0]   cnt;
    } vec_t;

    wr_rec_t           wq[$];
    logic [DATA_W-1:0] ed[$];
    vec_t              vt[NV];
    int                inv_wr = 0;
    logic              samp_vld = 1'b0;
    int                n_vec = 0;
    int                n_bad = 0;
    int                nwr, bad, found;
    bit                aborted;

    // Valid as seen by the DUT at the edge that produced the current bram_* values.
    always @(posedge user_clk) samp_vld <= bus.in_valid;

    always @(negedge user_clk) begin
        if (user_rst_n && bus.bram_we) begin
            wq.push_back('{addr: bus.bram_addr, din: bus.bram_din, dn: done, cnt: wr_count});
            if (!samp_vld) inv_wr++;
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_val(input bit arm, input int ch);
        return (32'(ch) << CH_SEL_LSB) | 32'(arm);
    endfunction

    task automatic drive(input logic v, input int ch, input logic [DATA_W-1:0] ph);
        bus.in_valid = v;
        bus.in_ch    = CH_W'(ch);
        bus.in_phase = ph;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //         dmp_on  vld   ch     phase      we    addr   din       busy  done  wr_count
        vt[0]  = '{32'h501, 1'b0, 8'd0, 16'h0000, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0, 11'd0};
        vt[1]  = '{32'h501, 1'b1, 8'd5, 16'h1111, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0, 11'd0};
        vt[2]  = '{32'h500, 1'b0, 8'd0, 16'h0000, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0, 11'd0};
        vt[3]  = '{32'h501, 1'b1, 8'd5, 16'h2222, 1'b0, 10'd0, 16'h0000, 1'b1, 1'b0, 11'd0};
        vt[4]  = '{32'h501, 1'b1, 8'd4, 16'h3333, 1'b0, 10'd0, 16'h0000, 1'b1, 1'b0, 11'd0};
        vt[5]  = '{32'h501, 1'b1, 8'd5, 16'h4444, 1'b1, 10'd0, 16'h4444, 1'b1, 1'b0, 11'd1};
        vt[6]  = '{32'h501, 1'b1, 8'd5, 16'h5555, 1'b1, 10'd1, 16'h5555, 1'b1, 1'b0, 11'd2};
        vt[7]  = '{32'h901, 1'b1, 8'd9, 16'h6666, 1'b0, 10'd1, 16'h5555, 1'b1, 1'b0, 11'd2};
        vt[8]  = '{32'h901, 1'b0, 8'd5, 16'h7777, 1'b0, 10'd1, 16'h5555, 1'b1, 1'b0, 11'd2};
        vt[9]  = '{32'h901, 1'b1, 8'd5, 16'h8000, 1'b1, 10'd2, 16'h8000, 1'b1, 1'b0, 11'd3};
        vt[10] = '{32'h900, 1'b0, 8'd5, 16'h9999, 1'b0, 10'd2, 16'h8000, 1'b0, 1'b0, 11'd3};
        vt[11] = '{32'h900, 1'b1, 8'd5, 16'h1234, 1'b0, 10'd2, 16'h8000, 1'b0, 1'b0, 11'd3};
        vt[12] = '{32'h901, 1'b1, 8'd9, 16'hAAAA, 1'b0, 10'd2, 16'h8000, 1'b1, 1'b0, 11'd0};
        vt[13] = '{32'h501, 1'b1, 8'd9, 16'hBBBB, 1'b1, 10'd0, 16'hBBBB, 1'b1, 1'b0, 11'd1};
        vt[14] = '{32'h501, 1'b1, 8'd5, 16'hCCCC, 1'b0, 10'd0, 16'hBBBB, 1'b1, 1'b0, 11'd1};
        vt[15] = '{32'h500, 1'b0, 8'd0, 16'h0000, 1'b0, 10'd0, 16'hBBBB, 1'b0, 1'b0, 11'd1};

        // Reset while the register already holds arm=1, ch_sel=5.
        user_rst_n = 1'b0;
        dmp_on     = reg_val(1, 5);
        drive(1'b0, 0, '0);
        repeat (3) @(posedge user_clk);
        #1 user_rst_n = 1'b1;
        chk("rst_we_addr_din", {bus.bram_we, bus.bram_addr, bus.bram_din}, '0);
        chk("rst_busy_done", {busy, done}, '0);
        chk("rst_wr_count", wr_count, '0);

        for (int i = 0; i < NV; i++) begin
            dmp_on = vt[i].dmp;
            drive(vt[i].vld, int'(vt[i].ch), vt[i].ph);
            tick();
            n_vec++;
            if ({bus.bram_we, bus.bram_addr, bus.bram_din, busy, done, wr_count} !==
                {vt[i].we, vt[i].addr, vt[i].din, vt[i].bsy, vt[i].dn, vt[i].cnt}) begin
                n_bad++;
                $display("FAIL vec%0d: got we=%b addr=%0d din=%h busy=%b done=%b cnt=%0d, want we=%b addr=%0d din=%h busy=%b done=%b cnt=%0d",
                         i, bus.bram_we, bus.bram_addr, bus.bram_din, busy, done, wr_count,
                         vt[i].we, vt[i].addr, vt[i].din, vt[i].bsy, vt[i].dn, vt[i].cnt);
            end
        end

        // Full-depth capture: channels 4..7 repeat, phase = ch*3 + frame, so ch5 carries 15+frame.
        wq.delete();
        dmp_on = reg_val(1, 5);
        drive(1'b0, 0, '0);
        tick();
        chk("fc_busy_after_arm", busy, 1);
        begin
            int c;
            for (c = 0; c < 4 * DEPTH + 64; c++) begin
                drive(1'b1, 4 + c % 4, 16'((4 + c % 4) * 3 + c / 4));
                tick();
                if (done) break;
            end
            chk("fc_done_seen", done, 1);
            for (int k = 1; k <= 16; k++) begin
                drive(1'b1, 4 + (c + k) % 4, 16'((4 + (c + k) % 4) * 3 + (c + k) / 4));
                tick();
            end
        end
        chk("fc_write_count", wq.size(), DEPTH);
        bad = 0;
        for (int k = 0; k < wq.size(); k++) begin
            if (wq[k].addr !== ADDR_W'(k) || wq[k].din !== 16'(15 + k) ||
                wq[k].cnt !== CW'(k + 1) || wq[k].dn !== (k == DEPTH - 1))
                bad++;
        end
        chk("fc_bad_records", bad, 0);
        chk("fc_last_done", (wq.size() == DEPTH) ? wq[DEPTH-1].dn : 1'b0, 1);
        chk("fc_wr_count_final", wr_count, DEPTH);
        chk("fc_busy_in_done", busy, 0);
        dmp_on = reg_val(0, 5);
        drive(1'b0, 0, '0);
        tick();
        chk("fc_done_falls", done, 0);

        // Abort after 300 writes.
        wq.delete();
        dmp_on = reg_val(1, 5);
        tick();
        nwr = 0;
        aborted = 0;
        for (int c = 0; c < 4000 && !aborted; c++) begin
            drive(1'b1, 4 + c % 4, 16'(c));
            tick();
            if (bus.bram_we) nwr++;
            if (nwr == 300) begin
                dmp_on = reg_val(0, 5);
                drive(1'b0, 0, '0);
                tick();
                aborted = 1;
            end
        end
        chk("ab_reached_300", aborted, 1);
        chk("ab_busy_done", {busy, done}, 2'b00);
        chk("ab_wr_count", wr_count, 300);
        for (int c = 0; c < 40; c++) begin
            drive(1'b1, 4 + c % 4, 16'(c));
            tick();
        end
        chk("ab_no_more_writes", wq.size(), 300);
        chk("ab_wr_count_held", wr_count, 300);

        // Gapped stream with random valid, including the most negative sample.
        wq.delete();
        ed.delete();
        inv_wr = 0;
        dmp_on = reg_val(1, 5);
        drive(1'b0, 0, '0);
        tick();
        for (int c = 0; c < 400; c++) begin
            logic v;
            logic [DATA_W-1:0] ph;
            int ch;
            ch = 4 + c % 4;
            v  = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            ph = (ch == 5 && (c / 4) % 2 == 0) ? 16'h8000 : 16'($urandom);
            drive(v, ch, ph);
            if (v && ch == 5) ed.push_back(ph);
            tick();
        end
        dmp_on = reg_val(0, 5);
        drive(1'b0, 0, '0);
        tick();
        tick();
        chk("gp_write_count", wq.size(), ed.size());
        bad = 0;
        found = 0;
        for (int k = 0; k < wq.size() && k < ed.size(); k++) begin
            if (wq[k].din !== ed[k] || wq[k].addr !== ADDR_W'(k)) bad++;
            if (wq[k].din === 16'h8000) found++;
        end
        chk("gp_bad_records", bad, 0);
        chk("gp_min_value_written", (found > 0), 1);
        chk("gp_writes_on_invalid", inv_wr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
